// File: rtl/insn_encoder.sv
// RV32I instruction encoder: field description in, 32-bit word out through a small FIFO.
// Illegal requests are swallowed and reported through err_o / err_code_o.
module insn_encoder #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [3:0]               cls_i,
    input  logic [2:0]               funct3_i,
    input  logic                     alt_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [31:0]              imm_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              insn_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNTW-1:0]          insn_cnt_o,
    output logic                     err_o,
    output logic [2:0]               err_code_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    logic signed [31:0] w_simm;
    logic [6:0]         w_f7;
    logic               w_shift;
    logic               w_r12;
    logic               w_bad_cls;
    logic               w_range_bad;
    logic               w_align_bad;
    logic               w_f3_bad;
    logic               w_alt_ok;
    logic [2:0]         w_code;
    logic               w_legal;
    logic [31:0]        w_word;

    logic [31:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [CNTW-1:0]    r_icnt;
    logic               r_err;
    logic [2:0]         r_code;

    logic               w_full;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;

    assign w_simm  = $signed(imm_i);
    assign w_f7    = alt_i ? 7'h20 : 7'h00;
    assign w_shift = (funct3_i == 3'd1) || (funct3_i == 3'd5);
    assign w_r12   = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);

    always_comb begin
        w_bad_cls   = 1'b0;
        w_range_bad = 1'b0;
        w_align_bad = 1'b0;
        w_f3_bad    = 1'b0;
        w_alt_ok    = 1'b0;
        w_word      = NOP;
        case (cls_i)
            4'd0: begin
                w_alt_ok = (funct3_i == 3'd0) || (funct3_i == 3'd5);
                w_word   = {w_f7, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            end
            4'd1: begin
                w_alt_ok = (funct3_i == 3'd5);
                if (w_shift) begin
                    w_range_bad = (w_simm < 32'sd0) || (w_simm > 32'sd31);
                    w_word = {w_f7, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
                end else begin
                    w_range_bad = w_r12;
                    w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                end
            end
            4'd2: begin
                w_range_bad = w_r12;
                w_f3_bad    = (funct3_i == 3'd3) || (funct3_i >= 3'd6);
                w_word      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LD};
            end
            4'd3: begin
                w_range_bad = w_r12;
                w_f3_bad    = (funct3_i > 3'd2);
                w_word      = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:0], OP_ST};
            end
            4'd4: begin
                w_range_bad = (w_simm < -32'sd4096) || (w_simm > 32'sd4094);
                w_align_bad = imm_i[0];
                w_f3_bad    = (funct3_i == 3'd2) || (funct3_i == 3'd3);
                w_word      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], OP_BR};
            end
            4'd5: begin
                w_range_bad = (w_simm < -32'sd1048576) ||
                              (w_simm > 32'sd1048574);
                w_align_bad = imm_i[0];
                w_word      = {imm_i[20], imm_i[10:1], imm_i[11],
                               imm_i[19:12], rd_i, OP_JAL};
            end
            4'd6: begin
                w_range_bad = w_r12;
                w_f3_bad    = (funct3_i != 3'd0);
                w_word      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JR};
            end
            4'd7: begin
                w_align_bad = (imm_i[11:0] != 12'd0);
                w_word      = {imm_i[31:12], rd_i, OP_LUI};
            end
            4'd8: begin
                w_align_bad = (imm_i[11:0] != 12'd0);
                w_word      = {imm_i[31:12], rd_i, OP_AUI};
            end
            default: w_bad_cls = 1'b1;
        endcase
    end

    // First failing check wins: class, range, alignment, funct3/alt.
    always_comb begin
        w_code = 3'd0;
        if (w_bad_cls)
            w_code = 3'd1;
        else if (w_range_bad)
            w_code = 3'd2;
        else if (w_align_bad)
            w_code = 3'd3;
        else if (w_f3_bad || (alt_i && !w_alt_ok))
            w_code = 3'd4;
    end

    assign w_legal = (w_code == 3'd0);

    assign w_full      = (r_count == CW'(DEPTH));
    assign req_ready_o = !w_full;
    assign w_acc       = req_valid_i && !w_full;
    assign w_push      = w_acc && w_legal && !flush_i;
    assign w_pop       = (r_count != '0) && out_ready_i && !flush_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_icnt  <= '0;
            r_err   <= 1'b0;
            r_code  <= 3'd0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_icnt <= r_icnt + CNTW'(1);
            end
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            r_err <= w_acc && !w_legal;
            if (w_acc && !w_legal)
                r_code <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_word;
    end

    assign out_valid_o = (r_count != '0);
    assign insn_o      = out_valid_o ? r_mem[r_rptr] : NOP;
    assign count_o     = r_count;
    assign insn_cnt_o  = r_icnt;
    assign err_o       = r_err;
    assign err_code_o  = r_code;

endmodule
